// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
//
// Purpose:
//   Controls an external two-port synchronous RAM (one write port, one read
//   port with a 1-cycle registered read) as a circular buffer. The block delays
//   a sample stream by a programmable number of samples. It sits between the
//   signal generator output and the DAC/plot path.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   en           1 = operate, 0 = idle (no RAM access)
//   delay        requested delay in samples, sampled every cycle
//   in_valid     input sample strobe
//   in_data      input sample
//   out_valid    registered output strobe, one cycle after an accepted sample
//   out_data     delayed sample, 0 whenever out_valid is 0
//   filled       buffer holds at least 'delay' valid samples
//   ram_wr       RAM write enable
//   ram_rd       RAM read enable
//   ram_wr_addr  RAM write address
//   ram_rd_addr  RAM read address
//   ram_din      RAM write data
//   ram_dout     RAM read data, valid the cycle after ram_rd
// -----------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     filled,
  output logic                     ram_wr,
  output logic                     ram_rd,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] wptr;
  logic [ADDRESS_WIDTH-1:0] fill_cnt;
  logic [ADDRESS_WIDTH-1:0] delay_q;
  logic                     in_run;
  logic                     accept;
  logic                     load_delay;
  logic                     pend_run;
  logic                     pend_bypass;
  logic [DATA_WIDTH-1:0]    bypass_data;

  // A FILL cycle whose count has already reached the delay behaves as RUN
  // straight away, so the sample arriving in that cycle is read back from the
  // buffer rather than being treated as one more fill sample.
  assign in_run     = (state == RUN) || ((state == FILL) && (fill_cnt == delay_q));
  assign accept     = en && (state != IDLE) && in_valid;
  assign load_delay = en && ((state == IDLE) || (delay != delay_q));

  assign filled      = in_run;
  assign ram_wr      = accept;
  assign ram_rd      = accept;
  assign ram_wr_addr = wptr;
  assign ram_rd_addr = wptr - delay_q;
  assign ram_din     = in_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A delay change restarts the fill and outranks the
  // FILL->RUN step; dropping en outranks everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FILL;
      FILL:    if (in_run) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && (delay != delay_q)) begin
      state_next = FILL;
    end
    if (!en) begin
      state_next = IDLE;
    end
  end

  // Write pointer, fill counter and the latched delay. The write pointer is
  // kept across idle periods; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      fill_cnt <= '0;
      delay_q  <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + ADDR_ONE;
      end
      if (load_delay) begin
        delay_q  <= delay;
        fill_cnt <= '0;
      end else if (accept && !in_run) begin
        fill_cnt <= fill_cnt + ADDR_ONE;
      end
    end
  end

  // Output pipeline stage, aligned with the RAM's registered read. With a zero
  // delay the read and write hit the same address in the same cycle, so the
  // sample is carried through a bypass register instead of the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      pend_run    <= 1'b0;
      pend_bypass <= 1'b0;
      bypass_data <= '0;
    end else begin
      out_valid   <= accept;
      pend_run    <= accept && in_run;
      pend_bypass <= accept && in_run && (delay_q == '0);
      if (accept) begin
        bypass_data <= in_data;
      end
    end
  end

  // Fill samples come out as zeros; only samples issued while running carry
  // buffered data.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (pend_bypass) begin
        out_data = bypass_data;
      end else if (pend_run) begin
        out_data = ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_delay_line_ctrl
//
// Purpose:
//   Self-checking bench for delay_line_ctrl. Two instances share the stream
//   inputs: one with the default 9-bit address and one with a 4-bit address to
//   exercise pointer wrap. Each instance has its own behavioural RAM with a
//   registered read. Expected values are hand-computed directed vectors.
// -----------------------------------------------------------------------------
module tb_delay_line_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;

  logic [8:0] delay9;
  logic       out_valid9;
  logic [7:0] out_data9;
  logic       filled9;
  logic       ram_wr9;
  logic       ram_rd9;
  logic [8:0] ram_wr_addr9;
  logic [8:0] ram_rd_addr9;
  logic [7:0] ram_din9;
  logic [7:0] ram_dout9;

  logic [3:0] delay4;
  logic       out_valid4;
  logic [7:0] out_data4;
  logic       filled4;
  logic       ram_wr4;
  logic       ram_rd4;
  logic [3:0] ram_wr_addr4;
  logic [3:0] ram_rd_addr4;
  logic [7:0] ram_din4;
  logic [7:0] ram_dout4;

  logic [7:0] mem9 [0:511];
  logic [7:0] mem4 [0:15];

  int checks_total;
  int checks_passed;

  delay_line_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut9 (
    .clk(clk), .rst_n(rst_n), .en(en), .delay(delay9),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid9), .out_data(out_data9), .filled(filled9),
    .ram_wr(ram_wr9), .ram_rd(ram_rd9),
    .ram_wr_addr(ram_wr_addr9), .ram_rd_addr(ram_rd_addr9),
    .ram_din(ram_din9), .ram_dout(ram_dout9)
  );

  delay_line_ctrl #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .delay(delay4),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid4), .out_data(out_data4), .filled(filled4),
    .ram_wr(ram_wr4), .ram_rd(ram_rd4),
    .ram_wr_addr(ram_wr_addr4), .ram_rd_addr(ram_rd_addr4),
    .ram_din(ram_din4), .ram_dout(ram_dout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: write-first is not modelled, a same-address read
  // returns the old contents.
  always @(posedge clk) begin
    if (ram_wr9) mem9[ram_wr_addr9] <= ram_din9;
    if (ram_rd9) ram_dout9 <= mem9[ram_rd_addr9];
    if (ram_wr4) mem4[ram_wr_addr4] <= ram_din4;
    if (ram_rd4) ram_dout4 <= mem4[ram_rd_addr4];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    #1;
  endtask

  // One accepted sample on the 9-bit instance: strobes in the issue cycle,
  // output one cycle later.
  task automatic sample9(input string tag, input int d, input int exp_out,
                         input int exp_filled, input int exp_wa, input int exp_ra);
    logic [7:0] dv;
    dv = d[7:0];
    applyStimulus(1'b1, dv);
    checkOutput({tag, " ram_wr"}, ram_wr9, 1);
    checkOutput({tag, " ram_rd"}, ram_rd9, 1);
    checkOutput({tag, " wr_addr"}, ram_wr_addr9, exp_wa);
    checkOutput({tag, " rd_addr"}, ram_rd_addr9, exp_ra);
    checkOutput({tag, " din"}, ram_din9, d);
    checkOutput({tag, " filled"}, filled9, exp_filled);
    step();
    checkOutput({tag, " out_valid"}, out_valid9, 1);
    checkOutput({tag, " out_data"}, out_data9, exp_out);
  endtask

  task automatic gap9(input string tag);
    applyStimulus(1'b0, 8'h00);
    checkOutput({tag, " gap ram_wr"}, ram_wr9, 0);
    checkOutput({tag, " gap ram_rd"}, ram_rd9, 0);
    step();
    checkOutput({tag, " gap out_valid"}, out_valid9, 0);
    checkOutput({tag, " gap out_data"}, out_data9, 0);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    delay9   = 9'd0;
    delay4   = 4'd15;

    // Reset state, with en and in_valid asserted to show they are ignored.
    #2;
    en = 1'b1;
    applyStimulus(1'b1, 8'h5A);
    checkOutput("rst out_valid", out_valid9, 0);
    checkOutput("rst out_data", out_data9, 0);
    checkOutput("rst filled", filled9, 0);
    checkOutput("rst ram_wr", ram_wr9, 0);
    checkOutput("rst ram_rd", ram_rd9, 0);
    step();
    step();
    en = 1'b0;
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    step();

    // Delay 3, back-to-back samples 1..8; the last two continue into RUN.
    delay9 = 9'd3;
    en     = 1'b1;
    applyStimulus(1'b0, 8'h00);
    step();
    for (int k = 1; k <= 8; k++) begin
      sample9($sformatf("d3 s%0d", k), k, (k >= 4) ? k - 3 : 0,
              (k >= 4) ? 1 : 0, k - 1, (k - 4) & 511);
    end

    // Delay change 3 -> 5 while running restarts the fill.
    delay9 = 9'd5;
    gap9("d5 change");
    checkOutput("d5 filled after change", filled9, 0);
    for (int k = 9; k <= 16; k++) begin
      sample9($sformatf("d5 s%0d", k), k, (k >= 14) ? k - 5 : 0,
              (k >= 14) ? 1 : 0, k - 1, (k - 6) & 511);
    end

    // In IDLE an in_valid produces no RAM access and no output.
    en = 1'b0;
    applyStimulus(1'b0, 8'h00);
    step();
    applyStimulus(1'b1, 8'hAA);
    checkOutput("idle ram_wr", ram_wr9, 0);
    checkOutput("idle ram_rd", ram_rd9, 0);
    checkOutput("idle filled", filled9, 0);
    step();
    checkOutput("idle out_valid", out_valid9, 0);

    // Sparse input, delay 2; write pointer resumes at 16.
    en     = 1'b1;
    delay9 = 9'd2;
    applyStimulus(1'b0, 8'h00);
    step();
    for (int j = 0; j < 4; j++) begin
      sample9($sformatf("sparse s%0d", j), 8'h21 + j, (j >= 2) ? 8'h21 + j - 2 : 0,
              (j >= 2) ? 1 : 0, 16 + j, 14 + j);
      gap9($sformatf("sparse g%0da", j));
      gap9($sformatf("sparse g%0db", j));
    end

    // Delay 0: bypass path, filled immediately, RAM still written.
    delay9 = 9'd0;
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("d0 filled", filled9, 1);
    sample9("d0 s0", 7, 7, 1, 20, 20);
    sample9("d0 s1", 9, 9, 1, 21, 21);
    gap9("d0 end");

    // Reset during RUN, then restart with delay 2.
    delay9 = 9'd2;
    applyStimulus(1'b0, 8'h00);
    step();
    sample9("pre-rst s0", 8'h31, 0, 0, 22, 20);
    sample9("pre-rst s1", 8'h32, 0, 0, 23, 21);
    sample9("pre-rst s2", 8'h33, 8'h31, 1, 24, 22);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h34);
    checkOutput("in-rst ram_wr", ram_wr9, 0);
    checkOutput("in-rst ram_rd", ram_rd9, 0);
    checkOutput("in-rst out_valid", out_valid9, 0);
    checkOutput("in-rst out_data", out_data9, 0);
    checkOutput("in-rst filled", filled9, 0);
    step();
    checkOutput("in-rst out_valid later", out_valid9, 0);
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    sample9("post-rst s0", 8'h51, 0, 0, 0, 510);
    sample9("post-rst s1", 8'h52, 0, 0, 1, 511);
    sample9("post-rst s2", 8'h53, 8'h51, 1, 2, 0);
    gap9("post-rst end");

    // Depth-16 instance, delay 15, 40 samples of value n across several wraps.
    rst_n = 1'b0;
    en    = 1'b0;
    step();
    rst_n  = 1'b1;
    delay4 = 4'd15;
    en     = 1'b1;
    applyStimulus(1'b0, 8'h00);
    step();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] nv;
      nv = n[7:0];
      applyStimulus(1'b1, nv);
      checkOutput($sformatf("wrap s%0d wr_addr", n), ram_wr_addr4, n % 16);
      checkOutput($sformatf("wrap s%0d rd_addr", n), ram_rd_addr4, (n + 1) % 16);
      step();
      checkOutput($sformatf("wrap s%0d out_valid", n), out_valid4, 1);
      checkOutput($sformatf("wrap s%0d out_data", n), out_data4, (n >= 15) ? n - 15 : 0);
    end
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("wrap end out_valid", out_valid4, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
